// File: rtl/ysyx_bus_sched.sv
// ysyx_bus_sched: shares one single-beat AXI4 master port among IFU fetch, LSU load and LSU store.
// One transaction in flight; owns grant order, request latching, 64-bit lane steering and a watchdog.
module ysyx_bus_sched #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] ifu_araddr,
   input  logic              ifu_arvalid,
   output logic [DATA_W-1:0] ifu_rdata_o,
   output logic              ifu_rvalid_o,
   input  logic [ADDR_W-1:0] lsu_araddr,
   input  logic              lsu_arvalid,
   input  logic [7:0]        lsu_rstrb,
   output logic [DATA_W-1:0] lsu_rdata_o,
   output logic              lsu_rvalid_o,
   input  logic [ADDR_W-1:0] lsu_awaddr,
   input  logic [DATA_W-1:0] lsu_wdata,
   input  logic [7:0]        lsu_wstrb,
   input  logic              lsu_wvalid,
   output logic              lsu_wready_o,
   output logic              io_master_arvalid,
   input  logic              io_master_arready,
   output logic [ADDR_W-1:0] io_master_araddr,
   output logic [2:0]        io_master_arsize,
   output logic [7:0]        io_master_arlen,
   output logic [1:0]        io_master_arburst,
   output logic [3:0]        io_master_arid,
   input  logic              io_master_rvalid,
   output logic              io_master_rready,
   input  logic              io_master_rlast,
   input  logic [63:0]       io_master_rdata,
   input  logic [1:0]        io_master_rresp,
   output logic              io_master_awvalid,
   input  logic              io_master_awready,
   output logic [ADDR_W-1:0] io_master_awaddr,
   output logic [2:0]        io_master_awsize,
   output logic [7:0]        io_master_awlen,
   output logic [1:0]        io_master_awburst,
   output logic [3:0]        io_master_awid,
   output logic              io_master_wvalid,
   input  logic              io_master_wready,
   output logic              io_master_wlast,
   output logic [63:0]       io_master_wdata,
   output logic [7:0]        io_master_wstrb,
   input  logic              io_master_bvalid,
   output logic              io_master_bready,
   input  logic [1:0]        io_master_bresp,
   output logic [1:0]        err_o
);

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
   localparam logic [WD_W-1:0] WD_HIT = WD_W'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic              owner_lsu, last_lsu;
   logic              mask_ifu, mask_ld, mask_st;
   logic [ADDR_W-1:0] addr;
   logic [7:0]        strb;
   logic [DATA_W-1:0] wdata;
   logic              aw_done, w_done;
   logic [WD_W-1:0]   wd_cnt;
   logic              grant_ifu, grant_ld, grant_st;
   logic              rd_done, wr_done, aw_hs, w_hs;
   logic              ifu_req, ld_req, st_req;
   logic [DATA_W-1:0] rd_lane;

   function automatic logic [2:0] strb_size(input logic [7:0] s);
      case (s)
         8'h01:   strb_size = 3'd0;
         8'h03:   strb_size = 3'd1;
         default: strb_size = 3'd2;
      endcase
   endfunction

   function automatic logic [DATA_W-1:0] rd_steer(input logic [63:0] d, input logic [2:0] a);
      logic [31:0] lane;
      lane = a[2] ? d[63:32] : d[31:0];
      rd_steer = DATA_W'(lane >> {a[1:0], 3'b000});
   endfunction

   function automatic logic [63:0] wr_steer(input logic [DATA_W-1:0] wd, input logic [1:0] a);
      logic [31:0] d;
      d = 32'(wd) << {a, 3'b000};
      wr_steer = {d, d};
   endfunction

   function automatic logic [7:0] strb_steer(input logic [7:0] s, input logic [2:0] a);
      logic [3:0] s4;
      s4 = s[3:0] << a[1:0];
      strb_steer = a[2] ? {s4, 4'h0} : {4'h0, s4};
   endfunction

   // A requester that just completed sits out its first IDLE cycle.
   assign ifu_req = ifu_arvalid & ~mask_ifu;
   assign ld_req  = lsu_arvalid & ~mask_ld;
   assign st_req  = lsu_wvalid  & ~mask_st;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt         = state;
      grant_ifu         = 1'b0;
      grant_ld          = 1'b0;
      grant_st          = 1'b0;
      rd_done           = 1'b0;
      wr_done           = 1'b0;
      aw_hs             = 1'b0;
      w_hs              = 1'b0;
      io_master_arvalid = 1'b0;
      io_master_rready  = 1'b0;
      io_master_awvalid = 1'b0;
      io_master_wvalid  = 1'b0;
      io_master_bready  = 1'b0;
      case (state)
         IDLE: begin
            if (st_req) begin
               grant_st  = 1'b1;
               state_nxt = WR_REQ;
            end else if (ifu_req && ld_req) begin
               grant_ifu = last_lsu;
               grant_ld  = ~last_lsu;
               state_nxt = RD_ADDR;
            end else if (ifu_req) begin
               grant_ifu = 1'b1;
               state_nxt = RD_ADDR;
            end else if (ld_req) begin
               grant_ld  = 1'b1;
               state_nxt = RD_ADDR;
            end
         end
         RD_ADDR: begin
            io_master_arvalid = 1'b1;
            if (io_master_arready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            io_master_rready = 1'b1;
            if (io_master_rvalid && io_master_rlast) begin
               rd_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         WR_REQ: begin
            io_master_awvalid = ~aw_done;
            io_master_wvalid  = ~w_done;
            aw_hs = io_master_awvalid & io_master_awready;
            w_hs  = io_master_wvalid & io_master_wready;
            if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            io_master_bready = 1'b1;
            if (io_master_bvalid) begin
               wr_done   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner_lsu <= 1'b0;
         last_lsu  <= 1'b1;
         mask_ifu  <= 1'b0;
         mask_ld   <= 1'b0;
         mask_st   <= 1'b0;
         addr      <= '0;
         strb      <= '0;
         wdata     <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         wd_cnt    <= '0;
         err_o     <= 2'b00;
      end else begin
         mask_ifu <= rd_done & ~owner_lsu;
         mask_ld  <= rd_done & owner_lsu;
         mask_st  <= wr_done;
         if (grant_st) begin
            addr    <= lsu_awaddr;
            strb    <= lsu_wstrb;
            wdata   <= lsu_wdata;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end
         if (grant_ifu) begin
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b0;
            addr      <= ifu_araddr;
            strb      <= 8'h0f;
         end
         if (grant_ld) begin
            owner_lsu <= 1'b1;
            last_lsu  <= 1'b1;
            addr      <= lsu_araddr;
            strb      <= lsu_rstrb;
         end
         if (aw_hs) aw_done <= 1'b1;
         if (w_hs)  w_done  <= 1'b1;
         // Watchdog saturates so the sticky flag is raised exactly once per stall.
         if (state == IDLE)        wd_cnt <= '0;
         else if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
         if (state != IDLE && wd_cnt == WD_HIT) err_o[1] <= 1'b1;
         if ((rd_done && io_master_rresp != 2'b00) || (wr_done && io_master_bresp != 2'b00))
            err_o[0] <= 1'b1;
      end
   end

   assign rd_lane      = rd_steer(io_master_rdata, addr[2:0]);
   assign ifu_rvalid_o = rd_done & ~owner_lsu & ifu_arvalid;
   assign lsu_rvalid_o = rd_done & owner_lsu & lsu_arvalid;
   assign ifu_rdata_o  = ifu_rvalid_o ? rd_lane : '0;
   assign lsu_rdata_o  = lsu_rvalid_o ? rd_lane : '0;
   assign lsu_wready_o = wr_done;

   assign io_master_araddr  = addr;
   assign io_master_arsize  = strb_size(strb);
   assign io_master_arlen   = 8'd0;
   assign io_master_arburst = 2'b01;
   assign io_master_arid    = 4'd0;
   assign io_master_awaddr  = addr;
   assign io_master_awsize  = strb_size(strb);
   assign io_master_awlen   = 8'd0;
   assign io_master_awburst = 2'b01;
   assign io_master_awid    = 4'd0;
   assign io_master_wlast   = io_master_wvalid;
   assign io_master_wdata   = wr_steer(wdata, addr[1:0]);
   assign io_master_wstrb   = strb_steer(strb, addr[2:0]);

endmodule

// File: tb/tb_ysyx_bus_sched.sv
// Scoreboard bench for ysyx_bus_sched: tasks play requesters and AXI slave and queue expectations,
// a negedge monitor pops and compares whenever the DUT handshakes or pulses a completion.
module tb_ysyx_bus_sched;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 40;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [AW-1:0] ifu_araddr, lsu_araddr, lsu_awaddr;
   logic ifu_arvalid, lsu_arvalid, lsu_wvalid;
   logic [7:0] lsu_rstrb, lsu_wstrb;
   logic [DW-1:0] lsu_wdata, ifu_rdata_o, lsu_rdata_o;
   logic ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o;
   logic io_master_arvalid, io_master_arready, io_master_rvalid, io_master_rready, io_master_rlast;
   logic [AW-1:0] io_master_araddr, io_master_awaddr;
   logic [2:0] io_master_arsize, io_master_awsize;
   logic [7:0] io_master_arlen, io_master_awlen, io_master_wstrb;
   logic [1:0] io_master_arburst, io_master_awburst, io_master_rresp, io_master_bresp, err_o;
   logic [3:0] io_master_arid, io_master_awid;
   logic [63:0] io_master_rdata, io_master_wdata;
   logic io_master_awvalid, io_master_awready, io_master_wvalid, io_master_wready, io_master_wlast;
   logic io_master_bvalid, io_master_bready;

   int n_tests = 0;
   int n_fail  = 0;
   logic exp_err0 = 1'b0;
   logic [34:0] q_ar[$];
   logic [34:0] q_aw[$];
   logic [71:0] q_w[$];
   logic [31:0] q_ifu[$];
   logic [31:0] q_lsu[$];
   bit          q_b[$];

   always #5 clk = ~clk;

   ysyx_bus_sched #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
      .ifu_rdata_o(ifu_rdata_o), .ifu_rvalid_o(ifu_rvalid_o),
      .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_rstrb(lsu_rstrb),
      .lsu_rdata_o(lsu_rdata_o), .lsu_rvalid_o(lsu_rvalid_o),
      .lsu_awaddr(lsu_awaddr), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
      .lsu_wvalid(lsu_wvalid), .lsu_wready_o(lsu_wready_o),
      .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
      .io_master_araddr(io_master_araddr), .io_master_arsize(io_master_arsize),
      .io_master_arlen(io_master_arlen), .io_master_arburst(io_master_arburst),
      .io_master_arid(io_master_arid),
      .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
      .io_master_rlast(io_master_rlast), .io_master_rdata(io_master_rdata),
      .io_master_rresp(io_master_rresp),
      .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
      .io_master_awaddr(io_master_awaddr), .io_master_awsize(io_master_awsize),
      .io_master_awlen(io_master_awlen), .io_master_awburst(io_master_awburst),
      .io_master_awid(io_master_awid),
      .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
      .io_master_wlast(io_master_wlast), .io_master_wdata(io_master_wdata),
      .io_master_wstrb(io_master_wstrb),
      .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
      .io_master_bresp(io_master_bresp),
      .err_o(err_o)
   );

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: byte-level view of the 64-bit bus.
   function automatic logic [2:0] m_size(input logic [7:0] s);
      if (s == 8'h01) return 3'd0;
      if (s == 8'h03) return 3'd1;
      return 3'd2;
   endfunction

   function automatic logic [31:0] m_load(input logic [63:0] d, input logic [31:0] a);
      logic [31:0] r;
      int base, off;
      r = '0;
      base = a[2] ? 4 : 0;
      off = int'(a[1:0]);
      for (int i = 0; i < 4; i++)
         if (off + i < 4) r[8*i +: 8] = d[8*(base + off + i) +: 8];
      return r;
   endfunction

   function automatic logic [71:0] m_store(input logic [31:0] wd, input logic [7:0] s, input logic [31:0] a);
      logic [63:0] d;
      logic [7:0] st;
      int base, off;
      d = '0;
      st = '0;
      base = a[2] ? 4 : 0;
      off = int'(a[1:0]);
      for (int i = 0; i < 4; i++)
         if (off + i < 4) begin
            d[8*(off + i) +: 8]      = wd[8*i +: 8];
            d[32 + 8*(off + i) +: 8] = wd[8*i +: 8];
            if (s[i]) st[base + off + i] = 1'b1;
         end
      return {d, st};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         if (io_master_arvalid && io_master_arready) begin
            if (q_ar.size() == 0) chk("ar_unexpected", 1, 0);
            else chk("ar_addr_size", {io_master_arsize, io_master_araddr}, q_ar.pop_front());
         end
         if (io_master_awvalid && io_master_awready) begin
            if (q_aw.size() == 0) chk("aw_unexpected", 1, 0);
            else chk("aw_addr_size", {io_master_awsize, io_master_awaddr}, q_aw.pop_front());
         end
         if (io_master_wvalid && io_master_wready) begin
            chk("wlast", io_master_wlast, 1);
            if (q_w.size() == 0) chk("w_unexpected", 1, 0);
            else chk("w_data_strb", {io_master_wdata, io_master_wstrb}, q_w.pop_front());
         end
         if (ifu_rvalid_o) begin
            if (q_ifu.size() == 0) chk("ifu_pulse_unexpected", 1, 0);
            else chk("ifu_rdata", ifu_rdata_o, q_ifu.pop_front());
         end else chk("ifu_rdata_zero", ifu_rdata_o, 0);
         if (lsu_rvalid_o) begin
            if (q_lsu.size() == 0) chk("lsu_pulse_unexpected", 1, 0);
            else chk("lsu_rdata", lsu_rdata_o, q_lsu.pop_front());
         end else chk("lsu_rdata_zero", lsu_rdata_o, 0);
         if (lsu_wready_o) begin
            chk("wready_pulse_expected", q_b.size() > 0, 1);
            if (q_b.size() > 0) void'(q_b.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b0;
      ifu_arvalid = 0; lsu_arvalid = 0; lsu_wvalid = 0;
      ifu_araddr = 0; lsu_araddr = 0; lsu_awaddr = 0;
      lsu_rstrb = 0; lsu_wstrb = 0; lsu_wdata = 0;
      io_master_arready = 0; io_master_rvalid = 0; io_master_rlast = 0;
      io_master_rdata = 0; io_master_rresp = 0;
      io_master_awready = 0; io_master_wready = 0; io_master_bvalid = 0; io_master_bresp = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_err0 = 1'b0;
   endtask

   task automatic wait_arvalid(output bit ok);
      int n;
      n = 0;
      while (!io_master_arvalid && n < 64) begin
         @(posedge clk); #1; n++;
      end
      ok = io_master_arvalid;
      if (!ok) chk("arvalid_wait", 0, 1);
   endtask

   task automatic serve_rd(input logic [63:0] d, input logic [1:0] resp, input int ad, input int rdl);
      bit ok;
      wait_arvalid(ok);
      if (!ok) return;
      repeat (ad) begin
         @(posedge clk); #1;
         chk("arvalid_stable", io_master_arvalid, 1);
      end
      io_master_arready = 1;
      @(posedge clk); #1;
      io_master_arready = 0;
      repeat (rdl) begin @(posedge clk); #1; end
      chk("rready", io_master_rready, 1);
      io_master_rvalid = 1; io_master_rlast = 1; io_master_rdata = d; io_master_rresp = resp;
      @(posedge clk); #1;
      io_master_rvalid = 0; io_master_rlast = 0; io_master_rresp = 0;
   endtask

   task automatic serve_wr(input logic [1:0] resp, input int awd, input int wd, input int bd);
      int n;
      n = 0;
      while (!io_master_awvalid && n < 64) begin
         @(posedge clk); #1; n++;
      end
      if (!io_master_awvalid) begin
         chk("awvalid_wait", 0, 1);
         return;
      end
      chk("wvalid_with_awvalid", io_master_wvalid, 1);
      fork
         begin
            repeat (awd) begin @(posedge clk); #1; end
            io_master_awready = 1;
            @(posedge clk); #1;
            io_master_awready = 0;
            chk("awvalid_dropped", io_master_awvalid, 0);
         end
         begin
            repeat (wd) begin @(posedge clk); #1; end
            io_master_wready = 1;
            @(posedge clk); #1;
            io_master_wready = 0;
            chk("wvalid_dropped", io_master_wvalid, 0);
         end
      join
      repeat (bd) begin @(posedge clk); #1; end
      chk("bready", io_master_bready, 1);
      io_master_bvalid = 1; io_master_bresp = resp;
      @(posedge clk); #1;
      io_master_bvalid = 0; io_master_bresp = 0;
   endtask

   task automatic rd(input bit lsu, input logic [31:0] a, input logic [7:0] s, input logic [63:0] d,
                     input logic [1:0] resp, input int ad, input int rdl);
      q_ar.push_back({m_size(lsu ? s : 8'h0f), a});
      if (lsu) q_lsu.push_back(m_load(d, a));
      else     q_ifu.push_back(m_load(d, a));
      if (resp != 2'b00) exp_err0 = 1'b1;
      if (lsu) begin lsu_araddr = a; lsu_rstrb = s; lsu_arvalid = 1; end
      else     begin ifu_araddr = a; ifu_arvalid = 1; end
      serve_rd(d, resp, ad, rdl);
      ifu_arvalid = 0; lsu_arvalid = 0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [7:0] s,
                     input logic [1:0] resp, input int awd, input int wd, input int bd);
      q_aw.push_back({m_size(s), a});
      q_w.push_back(m_store(d, s, a));
      q_b.push_back(1'b1);
      if (resp != 2'b00) exp_err0 = 1'b1;
      lsu_awaddr = a; lsu_wdata = d; lsu_wstrb = s; lsu_wvalid = 1;
      serve_wr(resp, awd, wd, bd);
      lsu_wvalid = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL global_time_limit: bench did not finish");
      $fatal(1, "time limit");
   end

   initial begin
      logic [31:0] a, d32;
      logic [63:0] d;
      logic [7:0] s;
      logic [1:0] resp;
      bit ok;
      int kind;

      do_reset();
      chk("reset_valids", {io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid,
                           io_master_bready, io_master_wlast}, 0);
      chk("reset_pulses", {ifu_rvalid_o, lsu_rvalid_o, lsu_wready_o}, 0);
      chk("reset_err", err_o, 0);
      chk("const_fields", {io_master_arlen, io_master_awlen, io_master_arburst, io_master_awburst,
                           io_master_arid, io_master_awid}, {8'd0, 8'd0, 2'b01, 2'b01, 4'd0, 4'd0});

      rd(0, 32'h3000_0004, 8'h00, 64'h1122_3344_5566_7788, 2'b00, 0, 0);
      rd(1, 32'h8000_0007, 8'h01, 64'hAABB_CCDD_0000_0000, 2'b00, 1, 2);
      wr(32'h8000_0006, 32'h0000_1234, 8'h03, 2'b00, 0, 2, 1);
      wr(32'h8000_0006, 32'h0000_1234, 8'h03, 2'b00, 2, 0, 0);
      wr(32'h8000_0000, 32'hDEAD_BEEF, 8'h0f, 2'b00, 1, 1, 0);

      for (int k = 0; k < 60; k++) begin
         kind = $urandom_range(0, 2);
         a = $urandom;
         d = {$urandom, $urandom};
         d32 = $urandom;
         case ($urandom_range(0, 3))
            0: s = 8'h01;
            1: s = 8'h03;
            2: s = 8'h0f;
            default: s = 8'($urandom);
         endcase
         resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         if (kind == 2) wr(a, d32, s, resp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         else rd(kind == 1, a, s, d, resp, $urandom_range(0, 3), $urandom_range(0, 3));
         chk("err_sticky", err_o, {1'b0, exp_err0});
      end

      do_reset();
      chk("err_after_reset", err_o, 0);
      rd(1, 32'h8000_0010, 8'h0f, 64'h0000_0000_CAFE_F00D, 2'b10, 0, 0);
      chk("err0_rresp", err_o, 2'b01);

      // Reset arrives in RD_DATA together with the data beat.
      ifu_araddr = 32'h3000_0010; ifu_arvalid = 1;
      q_ar.push_back({3'd2, 32'h3000_0010});
      wait_arvalid(ok);
      io_master_arready = 1;
      @(posedge clk); #1;
      io_master_arready = 0;
      chk("rd_data_reached", io_master_rready, 1);
      io_master_rvalid = 1; io_master_rlast = 1; io_master_rdata = 64'h1234_5678_9ABC_DEF0;
      rst = 0;
      #1;
      chk("midrst_valids", {io_master_arvalid, io_master_rready, io_master_awvalid, io_master_wvalid,
                            io_master_bready}, 0);
      chk("midrst_no_pulse", {ifu_rvalid_o, ifu_rdata_o}, 0);
      chk("midrst_err", err_o, 0);
      @(posedge clk); #1;
      chk("midrst_next_cycle", {io_master_arvalid, io_master_rready, ifu_rvalid_o, err_o}, 0);
      io_master_rvalid = 0; io_master_rlast = 0; ifu_arvalid = 0;
      rst = 1;

      // Both reads held for four grants; the model alternates starting with IFU.
      do_reset();
      ifu_araddr = 32'h1000_0008; lsu_araddr = 32'h2000_0001; lsu_rstrb = 8'h03;
      ifu_arvalid = 1; lsu_arvalid = 1;
      for (int k = 0; k < 4; k++) begin
         d = {$urandom, $urandom};
         if (k % 2 == 0) begin
            q_ar.push_back({3'd2, 32'h1000_0008});
            q_ifu.push_back(m_load(d, 32'h1000_0008));
         end else begin
            q_ar.push_back({3'd1, 32'h2000_0001});
            q_lsu.push_back(m_load(d, 32'h2000_0001));
         end
         if (k == 3) begin
            wait_arvalid(ok);
            lsu_awaddr = 32'h8000_0003; lsu_wdata = 32'h0000_005A; lsu_wstrb = 8'h01; lsu_wvalid = 1;
         end
         serve_rd(d, 2'b00, k % 2, 0);
      end
      q_aw.push_back({3'd0, 32'h8000_0003});
      q_w.push_back(m_store(32'h0000_005A, 8'h01, 32'h8000_0003));
      q_b.push_back(1'b1);
      serve_wr(2'b00, 0, 0, 0);
      lsu_wvalid = 0; ifu_arvalid = 0; lsu_arvalid = 0;
      @(posedge clk); #1;
      chk("arb_idle_after", {io_master_arvalid, io_master_awvalid}, 0);

      // Watchdog: arready withheld while the request sits in RD_ADDR.
      ifu_araddr = 32'h3000_0100; ifu_arvalid = 1;
      d = 64'h0BAD_F00D_7654_3210;
      q_ar.push_back({3'd2, 32'h3000_0100});
      q_ifu.push_back(m_load(d, 32'h3000_0100));
      wait_arvalid(ok);
      repeat (TO - 1) begin @(posedge clk); #1; end
      chk("wdog_not_yet", {err_o, io_master_arvalid}, 3'b001);
      @(posedge clk); #1;
      chk("wdog_fired", {err_o, io_master_arvalid}, 3'b101);
      serve_rd(d, 2'b00, 0, 0);
      ifu_arvalid = 0;
      chk("wdog_sticky", err_o, 2'b10);

      repeat (3) @(posedge clk);
      #1;
      chk("queues_drained", {32'(q_ar.size()), 32'(q_aw.size()), 32'(q_w.size())}, 0);
      chk("pulses_drained", {32'(q_ifu.size()), 32'(q_lsu.size()), 32'(q_b.size())}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ysyx_bus_sched.md
Name: ysyx_bus_sched

Overview:
- Sequences the single shared AXI4 master port among three requesters: IFU read, LSU load and LSU store.
- Supports one outstanding transaction, single-beat (arlen/awlen = 0, INCR).
- Sits between the IFU/LSU and the SoC master port. Owns grant order, address/data latching, 64-bit lane steering, the handshake state machine and a bus watchdog.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, requester data width
- TIMEOUT, 4096, cycles a transaction may stay outside IDLE before err_o[1] sets

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- ifu_araddr  in  ADDR_W  IFU fetch address
- ifu_arvalid  in  1  IFU request; held until ifu_rvalid_o
- ifu_rdata_o  out  DATA_W  fetch data
- ifu_rvalid_o  out  1  one-cycle fetch completion pulse
- lsu_araddr  in  ADDR_W  load address
- lsu_arvalid  in  1  load request; held until lsu_rvalid_o
- lsu_rstrb  in  8  load byte mask (0x1/0x3/0xf)
- lsu_rdata_o  out  DATA_W  load data, right-aligned
- lsu_rvalid_o  out  1  one-cycle load completion pulse
- lsu_awaddr  in  ADDR_W  store address
- lsu_wdata  in  DATA_W  store data, right-aligned
- lsu_wstrb  in  8  store byte mask
- lsu_wvalid  in  1  store request; held until lsu_wready_o
- lsu_wready_o  out  1  one-cycle store completion pulse
- io_master_arvalid/arready  out/in  1 each  AR handshake
- io_master_araddr  out  ADDR_W  read address
- io_master_arsize  out  3  read size
- io_master_arlen/awlen  out  8 each  constant 0
- io_master_arburst/awburst  out  2 each  constant 2'b01
- io_master_arid/awid  out  4 each  constant 0
- io_master_rvalid/rready/rlast  in/out/in  1 each  R handshake
- io_master_rdata  in  64  read data
- io_master_rresp  in  2  read response
- io_master_awvalid/awready  out/in  1 each  AW handshake
- io_master_awaddr  out  ADDR_W  write address
- io_master_awsize  out  3  write size
- io_master_wvalid/wready/wlast  out/in/out  1 each  W handshake; wlast = wvalid
- io_master_wdata  out  64  write data
- io_master_wstrb  out  8  write strobe
- io_master_bvalid/bready/bresp  in/out/in  1/1/2  B channel
- err_o  out  2  sticky: [0] non-OKAY rresp/bresp, [1] watchdog timeout

Behaviour:
- States:
  - IDLE
  - RD_ADDR
  - RD_DATA
  - WR_REQ
  - WR_RESP
- Reset (rst=0, async):
  - State goes to IDLE.
  - All io_master valid/ready outputs are 0; all completion pulses are 0.
  - err_o = 0; watchdog counter = 0; round-robin pointer favours IFU.
  - Latched registers are cleared to 0.
  - Reset mid-transaction abandons the transaction and emits no pulse.
- Grant (IDLE, evaluated every cycle):
  - Priority 1: lsu_wvalid → WR_REQ.
  - Otherwise reads are round-robin. If both reads are pending, grant the one not granted last; a single pending read wins.
  - The grant latches owner, address, strobe and write data. Requester inputs are ignored until the next IDLE.
  - Mask: the requester that completed on the previous cycle is masked for its first IDLE cycle, so a still-high valid cannot re-issue.
- RD_ADDR:
  - io_master_arvalid=1 from latched regs, stable until arready.
  - On arready → RD_DATA.
- RD_DATA:
  - io_master_rready=1.
  - On rvalid&rlast: the owner's rvalid_o pulses the same cycle (combinational) with steered data → IDLE.
  - If the owner's request is low at completion, the data is discarded and no pulse is emitted.
- Read steering:
  - lane = rdata[63:32] if addr[2], else [31:0].
  - Result = lane >> (8*addr[1:0]), zero-filled.
  - rdata_o is 0 whenever rvalid_o is 0.
- Sizes:
  - Strobe 0x1→0, 0x3→1, 0xf→2, any other value→2.
  - IFU reads always use size 2.
- WR_REQ:
  - awvalid and wvalid are both raised on entry.
  - Each drops independently after its own handshake, tracked by internal aw_done/w_done flags.
  - Both done, including in the same cycle → WR_RESP.
- Write steering:
  - wdata = {d,d} with d = lsu_wdata << (8*awaddr[1:0]).
  - wstrb = (wstrb[3:0] << awaddr[1:0]) placed in byte lanes [7:4] if awaddr[2], else [3:0].
- WR_RESP:
  - bready=1.
  - On bvalid: lsu_wready_o pulses the same cycle → IDLE.
- Errors:
  - A non-zero resp on the completing beat sets err_o[0].
  - The watchdog counts every non-IDLE cycle and clears in IDLE; reaching TIMEOUT sets err_o[1].
  - Neither error aborts the transaction. err_o clears only by reset.
- Throughput:
  - At least one IDLE cycle between transactions.
  - With arready and rvalid each arriving the cycle they are awaited, a read completes 2 cycles after its request is granted in IDLE.

Test Plan:
- Reset low mid-RD_DATA → next cycle: state IDLE, all master valids 0, no rvalid_o pulse, err_o=0.
- IFU fetch 0x30000004, rdata=0x11223344_55667788 → io_master_araddr=0x30000004, arsize=2, ifu_rdata_o=0x11223344 pulsed one cycle.
- LSU byte load 0x80000007 (rstrb=0x1), rdata upper lane=0xAABBCCDD → arsize=0, lsu_rdata_o=0x000000AA.
- LSU half store 0x80000006, wdata=0x1234, wstrb=0x3 → wdata=0x12340000_12340000, wstrb=0xC0, awsize=1. Run once with awready before wready and once with the reverse order; lsu_wready_o pulses exactly once after bvalid in both.
- IFU and LSU reads held together for 4 grants → grants alternate LSU/IFU (IFU first after reset). A store raised meanwhile is granted at the next IDLE ahead of both.
- rresp=2'b10 on a read → err_o[0]=1 and the data is still delivered. With arready held 0 for TIMEOUT cycles → err_o[1]=1 and arvalid stays high.
